// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator/state enums and BCD operand helpers for the keypad calculator
package calc_pkg;
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd13;
  localparam logic [3:0] KEY_CLEAR = 4'd14;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  typedef enum logic [2:0] {A_ENTRY, B_ENTRY, CALC, CONV, RESULT} state_t;

  typedef struct packed {
    logic [3:0] ten;
    logic [3:0] one;
  } bcd2_t;

  // A new digit enters only while the tens place is still empty.
  function automatic bcd2_t shift_digit(bcd2_t v, logic [3:0] d);
    return (v.ten == 4'd0) ? {v.one, d} : v;
  endfunction

  function automatic logic [6:0] bcd2_bin(bcd2_t v);
    return 7'(v.ten) * 7'd10 + 7'(v.one);
  endfunction

  function automatic op_t key_op(logic [3:0] k);
    return (k == KEY_SUB) ? OP_SUB : (k == KEY_MUL) ? OP_MUL : OP_ADD;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, RES_W shifts from start to a one-cycle done pulse
module bin2bcd_seq #(
  parameter int RES_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);
  localparam int CW = $clog2(RES_W + 1);

  logic [RES_W-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [15:0]      adj;

  // Add-3 correction on every BCD nibble that would overflow when doubled.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // The first shift happens on start (nothing to correct yet), the rest while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd  <= '0;
      sr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (clear) begin
      bcd  <= '0;
      sr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd <= {15'd0, bin[RES_W-1]};
        sr  <= bin << 1;
        cnt <= CW'(RES_W - 1);
        run <= 1'b1;
      end else if (run) begin
        bcd <= (adj << 1) | {15'd0, sr[RES_W-1]};
        sr  <= sr << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry sequencer, operand steering, calculation and BCD display drive
// Build option: define CALC_CHAIN_EN to let an operator key in RESULT reuse a small positive result as A.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int RES_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             busy,
  output logic [3:0]       disp_d3,
  output logic [3:0]       disp_d2,
  output logic [3:0]       disp_d1,
  output logic [3:0]       disp_d0,
  output logic             disp_neg,
  output logic [2:0]       state_o
);
  state_t           state, state_nx;
  bcd2_t            a, a_nx, b, b_nx;
  op_t              op, op_nx;
  logic [15:0]      res, res_nx;
  logic             neg, neg_nx;
  logic             start, clr, done;
  logic [15:0]      digits;
  logic [6:0]       a_bin, b_bin;
  logic [RES_W-1:0] bin;
  logic             is_digit, is_op, is_enter, is_clear;

  assign is_digit = key_valid && key_code <= 4'd9;
  assign is_op    = key_valid && (key_code == KEY_ADD || key_code == KEY_SUB || key_code == KEY_MUL);
  assign is_enter = key_valid && key_code == KEY_ENTER;
  assign is_clear = key_valid && key_code == KEY_CLEAR;

  assign a_bin = bcd2_bin(a);
  assign b_bin = bcd2_bin(b);
  assign bin   = (op == OP_ADD) ? RES_W'(a_bin) + RES_W'(b_bin) :
                 (op == OP_SUB) ? RES_W'(a_bin >= b_bin ? a_bin - b_bin : b_bin - a_bin) :
                                  RES_W'(a_bin) * RES_W'(b_bin);

  bin2bcd_seq #(.RES_W(RES_W)) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clr),
    .start(start),
    .bin  (bin),
    .done (done),
    .bcd  (digits)
  );

  // State register and all datapath registers of the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= A_ENTRY;
      a     <= '0;
      b     <= '0;
      op    <= OP_ADD;
      res   <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
      op    <= op_nx;
      res   <= res_nx;
      neg   <= neg_nx;
    end
  end

  // Next-state and datapath updates per key; CLEAR overrides everything including the converter.
  always_comb begin
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    op_nx    = op;
    res_nx   = res;
    neg_nx   = neg;
    start    = 1'b0;
    clr      = 1'b0;
    case (state)
      A_ENTRY: begin
        if (is_digit) a_nx = shift_digit(a, 4'(key_code));
        else if (is_op) begin
          op_nx    = key_op(4'(key_code));
          b_nx     = '0;
          state_nx = B_ENTRY;
        end
      end
      B_ENTRY: begin
        if (is_digit) b_nx = shift_digit(b, 4'(key_code));
        else if (is_op) op_nx = key_op(4'(key_code));
        else if (is_enter) state_nx = CALC;
      end
      CALC: begin
        start    = 1'b1;
        neg_nx   = (op == OP_SUB) && (a_bin < b_bin);
        state_nx = CONV;
      end
      CONV: begin
        if (done) begin
          res_nx   = digits;
          state_nx = RESULT;
        end
      end
      RESULT: begin
        if (is_digit) begin
          a_nx     = '{ten: 4'd0, one: 4'(key_code)};
          b_nx     = '0;
          neg_nx   = 1'b0;
          state_nx = A_ENTRY;
        end
`ifdef CALC_CHAIN_EN
        else if (is_op && !neg && res[15:8] == 8'd0) begin
          a_nx     = res[7:0];
          op_nx    = key_op(4'(key_code));
          b_nx     = '0;
          state_nx = B_ENTRY;
        end
`endif
      end
      default: state_nx = A_ENTRY;
    endcase
    if (is_clear) begin
      state_nx = A_ENTRY;
      a_nx     = '0;
      b_nx     = '0;
      op_nx    = OP_ADD;
      res_nx   = '0;
      neg_nx   = 1'b0;
      start    = 1'b0;
      clr      = 1'b1;
    end
  end

  assign busy     = (state == CALC) || (state == CONV);
  assign state_o  = state;
  assign disp_neg = (state == RESULT) && neg;
  assign {disp_d3, disp_d2, disp_d1, disp_d0} =
    (state == RESULT) ? res : {8'd0, (state == A_ENTRY) ? a : b};
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed and random key sequences checked against a value-level calculator model
module tb_calc_entry_ctrl;
  localparam int RES_W = 14;
  localparam int S_A = 0, S_B = 1, S_CALC = 2, S_CONV = 3, S_RES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       busy, disp_neg;
  logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0;
  logic [2:0] state_o;
  logic [15:0] disp;

  int n_chk = 0;
  int n_fail = 0;

  int m_st, m_a, m_b, m_op, m_res, m_cyc;
  bit m_neg;

  always #5 clk = ~clk;

  assign disp = {disp_d3, disp_d2, disp_d1, disp_d0};

  calc_entry_ctrl #(.KEY_W(4), .RES_W(RES_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .busy     (busy),
    .disp_d3  (disp_d3),
    .disp_d2  (disp_d2),
    .disp_d1  (disp_d1),
    .disp_d0  (disp_d0),
    .disp_neg (disp_neg),
    .state_o  (state_o)
  );

  task automatic m_reset();
    m_st = S_A; m_a = 0; m_b = 0; m_op = 10; m_res = 0; m_neg = 0; m_cyc = 0;
  endtask

  function automatic int shift2(int v, int d);
    return (v < 10) ? v * 10 + d : v;
  endfunction

  task automatic m_step(bit v, int c);
    bit dig, opk, ent;
    dig = v && c <= 9;
    opk = v && c >= 10 && c <= 12;
    ent = v && c == 13;
    if (v && c == 14) begin
      m_reset();
      return;
    end
    case (m_st)
      S_A: begin
        if (dig) m_a = shift2(m_a, c);
        else if (opk) begin m_op = c; m_b = 0; m_st = S_B; end
      end
      S_B: begin
        if (dig) m_b = shift2(m_b, c);
        else if (opk) m_op = c;
        else if (ent) m_st = S_CALC;
      end
      S_CALC: begin
        m_res = (m_op == 10) ? m_a + m_b : (m_op == 11) ? (m_a > m_b ? m_a - m_b : m_b - m_a) : m_a * m_b;
        m_neg = (m_op == 11) && (m_a < m_b);
        m_cyc = 0;
        m_st = S_CONV;
      end
      S_CONV: begin
        m_cyc++;
        if (m_cyc == RES_W) m_st = S_RES;
      end
      S_RES: begin
        if (dig) begin m_a = c; m_b = 0; m_st = S_A; end
`ifdef CALC_CHAIN_EN
        else if (opk && !m_neg && m_res <= 99) begin m_a = m_res; m_op = c; m_b = 0; m_st = S_B; end
`endif
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] exp_disp();
    int v;
    v = (m_st == S_RES) ? m_res : (m_st == S_A) ? m_a : m_b;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag);
    logic [15:0] ed;
    ed = exp_disp();
    n_chk++;
    assert (disp === ed) else begin
      n_fail++;
      $error("FAIL %s disp observed %h expected %h", tag, disp, ed);
    end
    n_chk++;
    assert (disp_neg === (m_st == S_RES && m_neg)) else begin
      n_fail++;
      $error("FAIL %s disp_neg observed %b expected %b", tag, disp_neg, (m_st == S_RES && m_neg));
    end
    n_chk++;
    assert (busy === (m_st == S_CALC || m_st == S_CONV)) else begin
      n_fail++;
      $error("FAIL %s busy observed %b expected %b", tag, busy, (m_st == S_CALC || m_st == S_CONV));
    end
    n_chk++;
    assert (state_o === 3'(m_st)) else begin
      n_fail++;
      $error("FAIL %s state observed %0d expected %0d", tag, state_o, m_st);
    end
  endtask

  task automatic expect_const(input string tag, input logic [15:0] want, input bit want_neg, input logic [2:0] want_st);
    n_chk++;
    assert (disp === want) else begin
      n_fail++;
      $error("FAIL %s disp observed %h expected %h", tag, disp, want);
    end
    n_chk++;
    assert (disp_neg === want_neg) else begin
      n_fail++;
      $error("FAIL %s disp_neg observed %b expected %b", tag, disp_neg, want_neg);
    end
    n_chk++;
    assert (state_o === want_st) else begin
      n_fail++;
      $error("FAIL %s state observed %0d expected %0d", tag, state_o, want_st);
    end
  endtask

  task automatic tick(input bit v, input int c, input string tag);
    key_valid = v;
    key_code  = 4'(c);
    @(posedge clk);
    m_step(v, c);
    #1;
    key_valid = 1'b0;
    check(tag);
  endtask

  task automatic key(input int c);
    tick(1'b1, c, "key");
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, "idle");
  endtask

  initial begin
    m_reset();
    #1;
    check("reset");
    expect_const("reset_const", 16'h0000, 1'b0, 3'd0);
    #2 rst_n = 1'b1;

    key(1); key(2); key(10); key(3); key(4); key(13);
    idle(14);
    n_chk++;
    assert (busy === 1'b1) else begin
      n_fail++;
      $error("FAIL add_busy_end busy observed %b expected 1", busy);
    end
    idle(1);
    expect_const("add_12_34", 16'h0046, 1'b0, 3'd4);

    key(3); key(11); key(4); key(7); key(13);
    idle(15);
    expect_const("sub_3_47", 16'h0044, 1'b1, 3'd4);

    key(9); key(9); key(12); key(9); key(9); key(13);
    key(5); key(13);
    idle(13);
    expect_const("mul_99_99", 16'h9801, 1'b0, 3'd4);

    key(5); key(0); key(7);
    expect_const("sat_507", 16'h0050, 1'b0, 3'd0);
    key(10); key(0); key(8);
    expect_const("b_08", 16'h0008, 1'b0, 3'd1);
    key(13);
    idle(15);
    expect_const("add_50_08", 16'h0058, 1'b0, 3'd4);

    key(14); key(1); key(10); key(2); key(13);
    idle(6);
    key(14);
    expect_const("clear_in_conv", 16'h0000, 1'b0, 3'd0);
    idle(2);

    key(6); key(10); key(7);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("async_rst");
    expect_const("async_rst_const", 16'h0000, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    key(4); key(10); key(5); key(13);
    idle(15);
    expect_const("chain_pre", 16'h0009, 1'b0, 3'd4);
    key(12); key(3); key(13);
    idle(15);
`ifdef CALC_CHAIN_EN
    expect_const("chain_mul", 16'h0027, 1'b0, 3'd4);
`else
    expect_const("chain_off", 16'h0003, 1'b0, 3'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      int c;
      bit v;
      v = 1'($urandom_range(0, 1));
      c = int'($urandom_range(0, 15));
      if (c == 14 && $urandom_range(0, 7) != 0) c = 13;
      tick(v, c, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
